alu_op_scheduler: RTL and testbench

//  Shares one 16-bit reversible-logic ALU between two requesters.
//  - Arbitrates between the requesters and registers the operands and the 4-bit function select onto the ALU inputs.
//  - Waits a fixed ALU settling latency, then captures the result and carry.
//  - Returns the result to the winning requester over a valid/ready response channel.
//  - Sits between the datapath masters and the ALU top (the bit-slice function-generator array).

---
 rtl/alu_op_scheduler.sv | 143 ++++++++++++++
 tb/tb_alu_op_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_scheduler.sv
// Arbitrates two requesters onto one shared ALU; round-robin unless ALU_SCHED_FIXED_PRIO_EN selects strict req0 priority.
// Latency: accept at T -> rsp_valid at T+ALU_LAT+1. Backpressure: response held until rsp_ready; no accepts while busy.
module alu_op_scheduler #(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_cout,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic grant1;
    logic is_idle;
    logic accept;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    assign grant1 = req1_valid && !req0_valid;
`else
    // On a tie, the requester that did not win last time goes next.
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);
`endif

    assign is_idle    = (state_q == ST_IDLE);
    assign accept     = is_idle && (req0_valid || req1_valid);
    // Gated by rst_n so nothing is handshaken while reset is held.
    assign req0_ready = rst_n && is_idle && req0_valid && !grant1;
    assign req1_ready = rst_n && is_idle && grant1;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        last_grant_d = last_grant_q;
        alu_sel_d    = alu_sel_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_cout_d   = rsp_cout_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_sel_d    = grant1 ? req1_sel : req0_sel;
                    alu_a_d      = grant1 ? req1_a : req0_a;
                    alu_b_d      = grant1 ? req1_b : req0_b;
                    rsp_id_d     = grant1;
                    last_grant_d = grant1;
                    lat_cnt_d    = LAT_INIT;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == 4'd0) begin
                    rsp_res_d   = alu_res;
                    rsp_cout_d  = alu_cout;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= 4'd0;
            last_grant_q <= 1'b1;
            alu_sel_q    <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            last_grant_q <= last_grant_d;
            alu_sel_q    <= alu_sel_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = !is_idle;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed steps plus random traffic against a transaction-level model.
module tb_alu_op_scheduler;
    localparam int WIDTH   = 16;
    localparam int ALU_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]       req0_sel, req1_sel, alu_sel;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_res, rsp_res;
    logic             alu_cout, rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;

    always #5 clk = ~clk;

    alu_op_scheduler #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_cout(rsp_cout), .busy(busy)
    );

    // Stand-in ALU: 1=add, 2=sub (cout=borrow), 3=and, 4=xor, others=or.
    function automatic logic [16:0] alu_model(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        case (s)
            4'h1:    return {1'b0, a} + {1'b0, b};
            4'h2:    return {1'b0, a} - {1'b0, b};
            4'h3:    return {1'b0, a & b};
            4'h4:    return {1'b0, a ^ b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign {alu_cout, alu_res} = alu_model(alu_sel, alu_a, alu_b);

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: one op outstanding from accept until its response handshake.
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_prev_rst = 1'b0;
    int          m_acc;
    bit          m_id;
    logic [3:0]  m_sel;
    logic [15:0] m_a, m_b;
    logic [16:0] m_exp;

    bit          s_r0, s_r1, s_rv;
    bit          hold0 = 1'b0, hold1 = 1'b0;
    logic [15:0] last_res;
    logic        last_cout, last_id;
    int          last_lat;
    int          n_rsp = 0;
    int          acc_q[$];
    bit          id_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_pay(input bit n);
        if (!n) begin
            req0_sel = 4'($urandom_range(0, 5)); req0_a = 16'($urandom); req0_b = 16'($urandom);
        end else begin
            req1_sel = 4'($urandom_range(0, 5)); req1_a = 16'($urandom); req1_b = 16'($urandom);
        end
    endtask

    // Entered at posedge+1 with this cycle's inputs driven; leaves at next posedge+1.
    task automatic cycle();
        bit e0, e1;
        int k;
        #1;
        s_r0 = req0_ready;
        s_r1 = req1_ready;
        s_rv = rsp_valid;
        if (m_prev_rst) begin
            check("rst_alu_sel", alu_sel, 0);
            check("rst_alu_a", alu_a, 0);
            check("rst_alu_b", alu_b, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_res", rsp_res, 0);
            check("rst_rsp_cout", rsp_cout, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_busy", busy, 0);
        end
        if (!rst_n) begin
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (!m_busy) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
            e0 = req0_valid;
`else
            e0 = req0_valid && (!req1_valid || m_last);
`endif
            e1 = req1_valid && !e0;
            check("idle_req0_ready", req0_ready, e0);
            check("idle_req1_ready", req1_ready, e1);
            check("idle_busy", busy, 0);
            check("idle_rsp_valid", rsp_valid, 0);
            if (e0 || e1) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_id   = e1;
                m_last = e1;
                m_sel  = e1 ? req1_sel : req0_sel;
                m_a    = e1 ? req1_a : req0_a;
                m_b    = e1 ? req1_b : req0_b;
                m_exp  = alu_model(m_sel, m_a, m_b);
                acc_q.push_back(cyc);
            end
        end else begin
            k = cyc - m_acc;
            check("busy_busy", busy, 1);
            check("busy_req0_ready", req0_ready, 0);
            check("busy_req1_ready", req1_ready, 0);
            check("alu_sel_hold", alu_sel, m_sel);
            check("alu_a_hold", alu_a, m_a);
            check("alu_b_hold", alu_b, m_b);
            check("rsp_valid_timing", rsp_valid, (k >= ALU_LAT + 1));
            if (k >= ALU_LAT + 1) begin
                check("rsp_res", rsp_res, m_exp[15:0]);
                check("rsp_cout", rsp_cout, m_exp[16]);
                check("rsp_id", rsp_id, m_id);
                if (rsp_ready) begin
                    m_busy    = 1'b0;
                    last_res  = rsp_res;
                    last_cout = rsp_cout;
                    last_id   = rsp_id;
                    last_lat  = k;
                    id_q.push_back(rsp_id);
                    n_rsp++;
                end
            end
        end
        m_prev_rst = !rst_n;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Requesters drop valid once accepted, or present a fresh op when held busy.
    task automatic step();
        cycle();
        if (req0_valid && s_r0) begin
            if (hold0) rnd_pay(1'b0); else req0_valid = 1'b0;
        end
        if (req1_valid && s_r1) begin
            if (hold1) rnd_pay(1'b1); else req1_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input string tag);
        int nr;
        nr = n_rsp;
        for (int k = 0; k < 60 && n_rsp == nr; k++) step();
        check(tag, n_rsp - nr, 1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && (req0_valid || req1_valid || m_busy); k++) step();
        check(tag, {req0_valid, req1_valid, busy}, 0);
    endtask

    initial begin
        int nr;
        bit rv_seen;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rnd_pay(1'b0); rnd_pay(1'b1);

        // Reset held with both requesters pending, then first grant
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("t1_first_grant_req0", s_r0, 1);
        check("t1_req1_waits", s_r1, 0);
        req1_valid = 1'b0;
        drain("t1_drain");

        // Single add
        req0_valid = 1'b1; req0_sel = 4'h1; req0_a = 16'h00FF; req0_b = 16'h0001;
        wait_rsp("t2_rsp_seen");
        check("t2_res", last_res, 16'h0100);
        check("t2_cout", last_cout, 0);
        check("t2_id", last_id, 0);
        check("t2_latency", last_lat, ALU_LAT + 1);

        // Both requesters continuously valid
        acc_q.delete(); id_q.delete();
        hold0 = 1'b1; hold1 = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rnd_pay(1'b0); rnd_pay(1'b1);
        for (int k = 0; k < 200 && id_q.size() < 4; k++) step();
        hold0 = 1'b0; hold1 = 1'b0;
        drain("t3_drain");
        check("t3_rsp_count", (id_q.size() >= 4), 1);
        for (int i = 0; i < 4 && i < id_q.size(); i++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
            check("t3_grant_id", id_q[i], 0);
`else
            check("t3_grant_id", id_q[i], (i % 2 == 0));
`endif
            if (i > 0) check("t3_spacing", acc_q[i] - acc_q[i-1], ALU_LAT + 2);
        end

        // Response backpressure
        rsp_ready = 1'b0; req0_valid = 1'b1; rnd_pay(1'b0);
        s_rv = 1'b0;
        for (int k = 0; k < 40 && !s_rv; k++) step();
        check("t4_rsp_valid_seen", s_rv, 1);
        repeat (5) step();
        check("t4_busy_stalled", busy, 1);
        rsp_ready = 1'b1;
        step();
        check("t4_idle_after_release", busy, 0);

        // Carry out and pass-through
        req0_valid = 1'b1; req0_sel = 4'h1; req0_a = 16'hFFFF; req0_b = 16'h0001;
        wait_rsp("t5_rsp_seen");
        check("t5_res", last_res, 16'h0000);
        check("t5_cout", last_cout, 1);

        // Reset one cycle after accept discards the op
        req1_valid = 1'b1; rnd_pay(1'b1);
        s_r1 = 1'b0;
        for (int k = 0; k < 20 && !s_r1; k++) step();
        check("t6_accepted", s_r1, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        nr = n_rsp; rv_seen = 1'b0;
        repeat (12) begin
            step();
            rv_seen = rv_seen | s_rv;
        end
        check("t6_no_rsp_valid", rv_seen, 0);
        check("t6_no_rsp", n_rsp - nr, 0);
        check("t6_idle", busy, 0);
        id_q.delete();
        hold0 = 1'b1; hold1 = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rnd_pay(1'b0); rnd_pay(1'b1);
        for (int k = 0; k < 100 && id_q.size() < 3; k++) step();
        hold0 = 1'b0; hold1 = 1'b0;
        drain("t6_drain");
        for (int i = 0; i < 3 && i < id_q.size(); i++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
            check("t6_grant_id", id_q[i], 0);
`else
            check("t6_grant_id", id_q[i], (i % 2 == 1));
`endif
        end

        // Random traffic
        nr = n_rsp;
        for (int k = 0; k < 400; k++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin req0_valid = 1'b1; rnd_pay(1'b0); end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin req1_valid = 1'b1; rnd_pay(1'b1); end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rsp_ready = 1'b1;
        drain("rnd_drain");
        check("rnd_progress", (n_rsp - nr > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
